// File: rtl/seg7_scan_decoder.sv
// Monitors multiplexed seven-segment pins, decodes each settled digit back to a
// nibble and publishes the 4-digit value once enough identical scans are seen.
module seg7_scan_decoder #(
   parameter int SETTLE  = 4,
   parameter int STABLE  = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic        ca,
   input  logic        cb,
   input  logic        cc,
   input  logic        cd,
   input  logic        ce,
   input  logic        cf,
   input  logic        cg,
   output logic [15:0] value,
   output logic        valid,
   output logic        update,
   output logic [3:0]  glyph_err,
   output logic [1:0]  dbg_state
);

   localparam int CTR_W   = (SETTLE  > 1) ? $clog2(SETTLE + 1)  : 1;
   localparam int MATCH_W = (STABLE  > 1) ? $clog2(STABLE + 1)  : 1;
   localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Returns {hit, nibble}; hit=0 for any pattern outside the hex glyph table.
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Returns {exactly_one_low, digit_index}; blank and ghosted anodes give 0.
   function automatic logic [2:0] anode_index(input logic [3:0] a);
      logic [2:0] r;
      case (a)
         4'b1110: r = 3'b100;
         4'b1101: r = 3'b101;
         4'b1011: r = 3'b110;
         4'b0111: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [3:0]         an_r_q, an_r_d, an_p_q, an_p_d;
   logic [6:0]         seg_r_q, seg_r_d, seg_p_q, seg_p_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [1:0]         samp_idx_q, samp_idx_d;
   logic [3:0]         samp_an_q, samp_an_d;
   logic [6:0]         samp_seg_q, samp_seg_d;
   logic [15:0]        scan_q, scan_d, prev_q, prev_d;
   logic [3:0]         mask_q, mask_d, err_q, err_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [15:0]        value_q, value_d;
   logic               valid_q, valid_d, update_q, update_d;

   logic [2:0]         sel;
   logic               stable;
   logic [4:0]         dec;
   logic [15:0]        scan_new;
   logic [3:0]         mask_new, err_new;
   logic [MATCH_W-1:0] match_nx;

   // Digit capture state machine.
   always_comb begin
      state_d    = state_q;
      ctr_d      = ctr_q;
      samp_idx_d = samp_idx_q;
      samp_an_d  = samp_an_q;
      samp_seg_d = samp_seg_q;
      an_r_d     = an;
      seg_r_d    = {cg, cf, ce, cd, cc, cb, ca};
      an_p_d     = an_r_q;
      seg_p_d    = seg_r_q;
      sel        = anode_index(an_r_q);
      stable     = (an_r_q == an_p_q) && (seg_r_q == seg_p_q);

      case (state_q)
         ST_WAIT: begin
            if (sel[2]) begin
               state_d = ST_SETTLE;
               ctr_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (!sel[2]) begin
               state_d = ST_WAIT;
               ctr_d   = '0;
            end else if (!stable) begin
               ctr_d = '0;
            end else if (ctr_q == CTR_W'(SETTLE - 1)) begin
               state_d    = ST_SAMPLE;
               ctr_d      = '0;
               samp_idx_d = sel[1:0];
               samp_an_d  = an_r_q;
               samp_seg_d = seg_r_q;
            end else begin
               ctr_d = ctr_q + CTR_W'(1);
            end
         end
         ST_SAMPLE: state_d = ST_HOLD;
         ST_HOLD: begin
            if (an_r_q != samp_an_q) state_d = ST_WAIT;
         end
         default: state_d = ST_WAIT;
      endcase
   end

   // Scan assembly, stability matching and timeout.
   always_comb begin
      scan_d   = scan_q;
      prev_d   = prev_q;
      mask_d   = mask_q;
      err_d    = err_q;
      match_d  = match_q;
      to_d     = to_q;
      value_d  = value_q;
      valid_d  = valid_q;
      update_d = 1'b0;

      dec      = decode_glyph(samp_seg_q);
      scan_new = scan_q;
      scan_new[{samp_idx_q, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
      mask_new = mask_q | (4'b0001 << samp_idx_q);
      err_new  = err_q | (dec[4] ? 4'b0000 : (4'b0001 << samp_idx_q));
      match_nx = (scan_new != prev_q)            ? MATCH_W'(1) :
                 (match_q == MATCH_W'(STABLE))   ? match_q     :
                                                   match_q + MATCH_W'(1);

      if (state_q == ST_SAMPLE) begin
         to_d = '0;
         if (mask_new == 4'hF) begin
            // Completed scan: the digit written this cycle takes part in the compare.
            scan_d  = scan_new;
            prev_d  = scan_new;
            mask_d  = 4'h0;
            err_d   = 4'h0;
            match_d = match_nx;
            if ((match_nx == MATCH_W'(STABLE)) && (err_new == 4'h0)) begin
               value_d  = scan_new;
               valid_d  = 1'b1;
               update_d = (scan_new != value_q) || !valid_q;
            end
         end else begin
            scan_d = scan_new;
            mask_d = mask_new;
            err_d  = err_new;
         end
      end else if (to_q != TO_W'(TIMEOUT)) begin
         to_d = to_q + TO_W'(1);
         if (to_q == TO_W'(TIMEOUT - 1)) begin
            valid_d = 1'b0;
            mask_d  = 4'h0;
            match_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_WAIT;
         an_r_q     <= 4'hF;
         seg_r_q    <= 7'h7F;
         an_p_q     <= 4'hF;
         seg_p_q    <= 7'h7F;
         ctr_q      <= '0;
         samp_idx_q <= 2'd0;
         samp_an_q  <= 4'hF;
         samp_seg_q <= 7'h7F;
         scan_q     <= 16'h0;
         prev_q     <= 16'h0;
         mask_q     <= 4'h0;
         err_q      <= 4'h0;
         match_q    <= '0;
         to_q       <= '0;
         value_q    <= 16'h0;
         valid_q    <= 1'b0;
         update_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         an_r_q     <= an_r_d;
         seg_r_q    <= seg_r_d;
         an_p_q     <= an_p_d;
         seg_p_q    <= seg_p_d;
         ctr_q      <= ctr_d;
         samp_idx_q <= samp_idx_d;
         samp_an_q  <= samp_an_d;
         samp_seg_q <= samp_seg_d;
         scan_q     <= scan_d;
         prev_q     <= prev_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
         match_q    <= match_d;
         to_q       <= to_d;
         value_q    <= value_d;
         valid_q    <= valid_d;
         update_q   <= update_d;
      end
   end

   assign value     = value_q;
   assign valid     = valid_q;
   assign update    = update_q;
   assign glyph_err = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans, mid-scan changes, glitches,
// bad glyphs, timeout and reset, each checked with an immediate assertion.
module tb_seg7_scan_decoder;

   localparam int T_OUT = 100;
   localparam int DWELL = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  seg_drv;
   logic [15:0] value;
   logic        valid;
   logic        update;
   logic [3:0]  glyph_err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int upd_cnt  = 0;

   seg7_scan_decoder #(.SETTLE(4), .STABLE(2), .TIMEOUT(T_OUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .an        (an),
      .ca        (seg_drv[0]),
      .cb        (seg_drv[1]),
      .cc        (seg_drv[2]),
      .cd        (seg_drv[3]),
      .ce        (seg_drv[4]),
      .cf        (seg_drv[5]),
      .cg        (seg_drv[6]),
      .value     (value),
      .valid     (valid),
      .update    (update),
      .glyph_err (glyph_err),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (update === 1'b1) upd_cnt++;

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a falling edge and are held for n cycles.
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an      = a;
      seg_drv = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic show_digit(input int k, input logic [6:0] s);
      drive(~(4'b0001 << k), s, DWELL);
   endtask

   task automatic scan(input logic [15:0] v);
      for (int k = 0; k < 4; k++) show_digit(k, hex_seg(v[4*k +: 4]));
   endtask

   initial begin
      rst     = 1'b0;
      an      = 4'hF;
      seg_drv = 7'h7F;
      repeat (3) @(negedge clk);
      check("rst_value", value, 16'h0);
      check("rst_valid", {15'b0, valid}, 16'h0);
      check("rst_update", {15'b0, update}, 16'h0);
      check("rst_glyph_err", {12'b0, glyph_err}, 16'h0);
      rst = 1'b1;
      @(negedge clk);

      // Test 1: steady 0x12A4
      scan(16'h12A4);
      check("t1_scan1_valid", {15'b0, valid}, 16'h0);
      check("t1_scan1_value", value, 16'h0);
      scan(16'h12A4);
      check("t1_value", value, 16'h12A4);
      check("t1_valid", {15'b0, valid}, 16'h1);
      scan(16'h12A4);
      check("t1_update_count", upd_cnt[15:0], 16'd1);

      // Test 2: change to 0x006F mid-scan
      show_digit(0, hex_seg(4'h4));
      show_digit(1, hex_seg(4'hA));
      show_digit(2, hex_seg(4'h0));
      show_digit(3, hex_seg(4'h0));
      check("t2_mixed_value", value, 16'h12A4);
      scan(16'h006F);
      check("t2_first_value", value, 16'h12A4);
      check("t2_first_updates", upd_cnt[15:0], 16'd1);
      scan(16'h006F);
      check("t2_value", value, 16'h006F);
      check("t2_updates", upd_cnt[15:0], 16'd2);

      // Test 3: ghosted anodes and segments that never settle
      drive(4'b1100, 7'h40, 2);
      drive(4'hF, 7'h7F, 3);
      for (int i = 0; i < 5; i++) drive(4'b1110, (i % 2) ? 7'h00 : 7'h7F, 2);
      drive(4'hF, 7'h7F, 4);
      check("t3_glyph_err", {12'b0, glyph_err}, 16'h0);
      check("t3_value", value, 16'h006F);
      check("t3_valid", {15'b0, valid}, 16'h1);

      // Test 4: blank pattern on digit 2, scanned twice
      for (int r = 0; r < 2; r++) begin
         show_digit(0, hex_seg(4'hF));
         show_digit(1, hex_seg(4'h6));
         show_digit(2, 7'h7F);
         check("t4_glyph_err_mid", {12'b0, glyph_err}, 16'h0004);
         show_digit(3, hex_seg(4'h1));
         check("t4_glyph_err_end", {12'b0, glyph_err}, 16'h0);
      end
      check("t4_value", value, 16'h006F);
      check("t4_valid", {15'b0, valid}, 16'h1);
      check("t4_updates", upd_cnt[15:0], 16'd2);

      // Test 5: reload 0x12A4, then blank anodes until timeout
      scan(16'h12A4);
      scan(16'h12A4);
      check("t5_value", value, 16'h12A4);
      check("t5_updates", upd_cnt[15:0], 16'd3);
      drive(4'hF, 7'h7F, T_OUT - 13);
      check("t5_valid_before", {15'b0, valid}, 16'h1);
      @(negedge clk);
      check("t5_valid_at_timeout", {15'b0, valid}, 16'h0);
      drive(4'hF, 7'h7F, 30);
      check("t5_valid_stays_low", {15'b0, valid}, 16'h0);
      check("t5_value_held", value, 16'h12A4);

      // Test 6: reset in the middle of a scan
      scan(16'h12A4);
      scan(16'h12A4);
      show_digit(0, hex_seg(4'h4));
      show_digit(1, 7'h7F);
      check("t6_err_before_rst", {12'b0, glyph_err}, 16'h0002);
      rst = 1'b0;
      drive(4'hF, 7'h7F, 1);
      check("t6_rst_value", value, 16'h0);
      check("t6_rst_valid", {15'b0, valid}, 16'h0);
      check("t6_rst_update", {15'b0, update}, 16'h0);
      check("t6_rst_glyph_err", {12'b0, glyph_err}, 16'h0);
      rst = 1'b1;
      drive(4'hF, 7'h7F, 2);
      scan(16'h12A4);
      check("t6_scan1_valid", {15'b0, valid}, 16'h0);
      scan(16'h12A4);
      check("t6_value", value, 16'h12A4);
      check("t6_valid", {15'b0, valid}, 16'h1);
      check("t6_updates", upd_cnt[15:0], 16'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
